alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 184 ++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered single-issue ALU execute stage with iterative SLL.
// Latency: 1 cycle accept-to-out_valid for all ops; SLL with shamt>0 takes shamt+1.
// Backpressure: a result is held in DONE until out_ready; in_ready drops while
//   shifting, while a result is stalled, and during reset.
//
// Ports:
//   clk, reset          sole clock, synchronous active-high reset
//   in_valid/in_ready   input handshake for {alu_operation, a, b, shamt}
//   out_valid/out_ready output handshake for {result, zero[, overflow]}
//   result, zero        registered result and result==0 flag
//   overflow            signed ADD/SUB overflow, only when ALU_OVERFLOW_EN is defined
//
// Build option: define ALU_OVERFLOW_EN to add the overflow port and its logic.
// WIDTH must equal 2**SHAMT_W.

module alu_exec_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_operation,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
`ifdef ALU_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  // Combinational ALU datapath
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] alu_res;
  logic             slt_res;
  logic [WIDTH-1:0] sh_next;
  logic             accept;
  logic             start_shift;
`ifdef ALU_OVERFLOW_EN
  logic             alu_ovf;
`endif

  assign add_res = a + b;
  assign sub_res = a - b;
  assign slt_res = ($signed(a) < $signed(b));
  assign sh_next = sh_q << 1;

  always_comb begin
    alu_res = '0;
    case (alu_operation)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = add_res;
      OP_SUB:  alu_res = sub_res;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_res};
      OP_NOR:  alu_res = ~(a | b);
      // Only reached with shamt==0 in practice; larger shifts go through SHIFT.
      OP_SLL:  alu_res = b << shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    alu_ovf = 1'b0;
    case (alu_operation)
      OP_ADD:  alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  end
`endif

  // A new bundle is taken from IDLE, or from DONE in the same cycle the
  // held result drains, giving one result per cycle back-to-back.
  assign in_ready    = !reset && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept      = in_valid && in_ready;
  assign start_shift = (alu_operation == OP_SLL) && (shamt != '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
`ifdef ALU_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (start_shift) begin
            state_d = SHIFT;
            sh_d    = b;
            cnt_d   = shamt;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
`ifdef ALU_OVERFLOW_EN
            ovf_d    = alu_ovf;
`endif
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - SHAMT_W'(1);
        // cnt_q==1 means this edge performs the last single-bit shift.
        if (cnt_q == SHAMT_W'(1)) begin
          state_d  = DONE;
          result_d = sh_next;
          zero_d   = (sh_next == '0);
`ifdef ALU_OVERFLOW_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      sh_q     <= '0;
      cnt_q    <= '0;
`ifdef ALU_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
`ifdef ALU_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
`ifdef ALU_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed-vector bench for alu_exec_stage.
// Inputs change 1ns after the rising edge; outputs are sampled at that point too.
// Expected values are hand-computed constants.

module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_operation;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int n_vec;
  int n_err;

  alu_exec_stage #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_operation (alu_operation),
    .a             (a),
    .b             (b),
    .shamt         (shamt),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow      (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, wait for the result, check latency/result/zero,
  // then let it drain (out_ready is held high).
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [4:0] sh,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    out_ready     = 1'b1;
    alu_operation = op;
    a             = va;
    b             = vb;
    shamt         = sh;
    in_valid      = 1'b1;
    chk({tag, ".rdy"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, result, exp);
    chk({tag, ".zero"}, zero, (exp == 32'h0));
    step();
    chk({tag, ".drain"}, out_valid, 0);
  endtask

`ifdef ALU_OVERFLOW_EN
  task automatic ovf_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp, input logic exp_ovf);
    out_ready     = 1'b1;
    alu_operation = op;
    a             = va;
    b             = vb;
    shamt         = 5'd0;
    in_valid      = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, ".vld"}, out_valid, 1);
    chk({tag, ".res"}, result, exp);
    chk({tag, ".ovf"}, overflow, exp_ovf);
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_vec         = 0;
    n_err         = 0;
    reset         = 1'b1;
    in_valid      = 1'b0;
    alu_operation = 4'h0;
    a             = '0;
    b             = '0;
    shamt         = '0;
    out_ready     = 1'b0;

    // Reset state
    step();
    step();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.zero", zero, 1);
    reset = 1'b0;
    #1;
    chk("rst.rdy_after", in_ready, 1);

    // ADD 5+3, then hold with out_ready low for 3 cycles
    alu_operation = 4'b0010; a = 32'h5; b = 32'h3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("add.vld", out_valid, 1);
    chk("add.res", result, 32'h8);
    chk("add.zero", zero, 0);
    for (int i = 0; i < 3; i++) begin
      chk("hold.rdy", in_ready, 0);
      chk("hold.vld", out_valid, 1);
      chk("hold.res", result, 32'h8);
      step();
    end

    // Back-to-back ADDs with out_ready high
    out_ready = 1'b1;
    alu_operation = 4'b0010; a = 32'h1; b = 32'h2; in_valid = 1'b1;
    #1;
    chk("b2b.rdy", in_ready, 1);
    step();
    chk("b2b1.vld", out_valid, 1);
    chk("b2b1.res", result, 32'h3);
    a = 32'd10; b = 32'd20;
    step();
    chk("b2b2.vld", out_valid, 1);
    chk("b2b2.res", result, 32'd30);
    in_valid = 1'b0;
    step();
    chk("b2b.idle", out_valid, 0);

    // Directed op vectors
    do_op("sub_eq",  4'b0110, 32'h12345678, 32'h12345678, 5'd0, 32'h00000000, 1);
    do_op("sub_neg", 4'b0110, 32'h00000000, 32'h00000001, 5'd0, 32'hFFFFFFFF, 1);
    do_op("slt_t",   4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1);
    do_op("slt_f",   4'b0111, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1);
    do_op("and",     4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1);
    do_op("or",      4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 1);
    do_op("nor",     4'b1100, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0, 32'h00000000, 1);
    do_op("nor2",    4'b1100, 32'h0000FFFF, 32'h00FF0000, 5'd0, 32'hFF000000, 1);
    do_op("add_wrap",4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1);
    do_op("undef",   4'b0101, 32'h00000005, 32'h00000005, 5'd3, 32'h00000000, 1);
    do_op("sll0",    4'b0011, 32'h00000000, 32'h00000003, 5'd0, 32'h00000003, 1);
    do_op("sll1",    4'b0011, 32'h00000000, 32'h80000001, 5'd1, 32'h00000002, 2);
    do_op("sll31",   4'b0011, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 32);
    do_op("sll_z",   4'b0011, 32'h00000000, 32'h00000002, 5'd31, 32'h00000000, 32);

    // SLL shamt=4: in_ready low for 4 cycles, inputs ignored while shifting
    out_ready = 1'b1;
    alu_operation = 4'b0011; b = 32'h1; shamt = 5'd4; in_valid = 1'b1;
    step();
    alu_operation = 4'b0000; a = 32'h0; b = 32'h0; shamt = 5'd0;
    for (int i = 1; i <= 4; i++) begin
      chk("sll4.rdy", in_ready, 0);
      chk("sll4.vld", out_valid, 0);
      step();
    end
    in_valid = 1'b0;
    chk("sll4.vld5", out_valid, 1);
    chk("sll4.res", result, 32'h10);
    chk("sll4.zero", zero, 0);
    step();
    chk("sll4.drain", out_valid, 0);

    // Reset in the middle of a 31-bit shift
    alu_operation = 4'b0011; b = 32'h1; shamt = 5'd31; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("rmid.vld", out_valid, 0);
    chk("rmid.res", result, 0);
    chk("rmid.zero", zero, 1);
    chk("rmid.rdy_in_rst", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("rmid.rdy", in_ready, 1);
    for (int i = 0; i < 35; i++) step();
    chk("rmid.no_result", out_valid, 0);

`ifdef ALU_OVERFLOW_EN
    ovf_op("ovf_add", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1);
    ovf_op("ovf_and", 4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
    ovf_op("ovf_sub", 4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);
    ovf_op("ovf_subn",4'b0110, 32'h00000005, 32'h00000003, 32'h00000002, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
